// File: rtl/pi_stim_pkg.sv
// Shared types and constants for the primary-input stimulus generator.
// Holds the run FSM encoding, polynomial constants and the LFSR step.
package pi_stim_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXHAUST = 2'd1,
    RANDOM  = 2'd2,
    DONE    = 2'd3
  } stim_state_e;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          COUNT_W   = 16;

  // Galois form, shifting right; taps fold back in when bit 0 falls out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/misr_accum.sv
// Multiple-input signature register compacting the DUT outputs.
// Cleared at the start of a run, advanced once per accepted pattern.
module misr_accum
  import pi_stim_pkg::*;
#(
  parameter int PO_W   = 5,
  parameter int MISR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [PO_W-1:0]   din,
  output logic [MISR_W-1:0] sig
);

  localparam logic [MISR_W-1:0] POLY = MISR_W'(MISR_POLY);

  logic [MISR_W-1:0] sig_q;
  logic [MISR_W-1:0] sig_d;

  always_comb begin
    sig_d = {sig_q[MISR_W-2:0], 1'b0} ^ (sig_q[MISR_W-1] ? POLY : '0) ^ MISR_W'(din);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else if (clr) begin
      sig_q <= '0;
    end else if (en) begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/pi_stimulus_gen.sv
// Stimulus source for combinational regression netlists: exhaustive sweep,
// then LFSR patterns, with the DUT outputs compacted into a MISR signature.
module pi_stimulus_gen
  import pi_stim_pkg::*;
#(
  parameter int          PI_W       = 6,
  parameter int          PO_W       = 5,
  parameter int          RAND_COUNT = 256,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          MISR_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [PI_W-1:0]    pi_data,
  output logic               pi_valid,
  input  logic               pi_ready,
  input  logic [PO_W-1:0]    po_data,
  output logic               busy,
  output logic               done,
  output logic [MISR_W-1:0]  signature,
  output logic [COUNT_W-1:0] pattern_count
);

  localparam bit                 HAS_RAND  = (RAND_COUNT > 0);
  localparam logic [COUNT_W-1:0] RAND_LAST = COUNT_W'(RAND_COUNT - 1);
  localparam logic [PI_W-1:0]    SWEEP_END = {PI_W{1'b1}};

  stim_state_e        state_q;
  logic [PI_W-1:0]    pi_data_q;
  logic               pi_valid_q;
  logic               busy_q;
  logic               done_q;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] rand_cnt_q;
  logic [15:0]        lfsr_q;

  logic               hs;
  logic               start_ok;
  logic [15:0]        lfsr_d;
  logic [COUNT_W-1:0] count_d;

  assign hs       = pi_valid_q & pi_ready;
  assign start_ok = start & ((state_q == IDLE) | (state_q == DONE));
  assign lfsr_d   = lfsr_step(lfsr_q);
  assign count_d  = (count_q == {COUNT_W{1'b1}}) ? count_q : count_q + 1'b1;

  // pi_data_q doubles as the sweep counter while in EXHAUST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pi_data_q  <= '0;
      pi_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      rand_cnt_q <= '0;
      lfsr_q     <= LFSR_SEED;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= EXHAUST;
            pi_data_q  <= '0;
            pi_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            count_q    <= '0;
            rand_cnt_q <= '0;
            lfsr_q     <= LFSR_SEED;
          end
        end
        EXHAUST: begin
          if (hs) begin
            count_q <= count_d;
            if (pi_data_q != SWEEP_END) begin
              pi_data_q <= pi_data_q + 1'b1;
            end else if (HAS_RAND) begin
              state_q   <= RANDOM;
              pi_data_q <= lfsr_q[PI_W-1:0];
            end else begin
              state_q    <= DONE;
              pi_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        RANDOM: begin
          if (hs) begin
            count_q    <= count_d;
            lfsr_q     <= lfsr_d;
            rand_cnt_q <= rand_cnt_q + 1'b1;
            if (rand_cnt_q == RAND_LAST) begin
              state_q    <= DONE;
              pi_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              pi_data_q <= lfsr_d[PI_W-1:0];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  misr_accum #(
    .PO_W  (PO_W),
    .MISR_W(MISR_W)
  ) u_misr (
    .clk(clk),
    .rst(rst),
    .clr(start_ok),
    .en (hs),
    .din(po_data),
    .sig(signature)
  );

  assign pi_data       = pi_data_q;
  assign pi_valid      = pi_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pattern_count = count_q;

endmodule

// File: tb/tb_pi_stimulus_gen.sv
// Randomized self-checking bench for pi_stimulus_gen against a pattern-list
// and arithmetic MISR reference model.
module tb_pi_stimulus_gen;

  localparam int N_RUN = 320;
  localparam int N_R0  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        start0 = 1'b0;
  logic        ready = 1'b1;
  logic        ready0 = 1'b1;
  logic [4:0]  po = '0;
  logic [5:0]  pi_data, pi_data0;
  logic        pi_valid, pi_valid0, busy, busy0, done, done0;
  logic [15:0] signature, signature0, pattern_count, pattern_count0;

  int          checks = 0;
  int          passes = 0;
  int          nprint = 0;
  int          exp_pat [N_RUN];
  logic [4:0]  po_tab [N_RUN];
  logic [15:0] sig_first;

  always #5 clk = ~clk;

  pi_stimulus_gen dut (
    .clk(clk), .rst(rst), .start(start), .pi_data(pi_data), .pi_valid(pi_valid),
    .pi_ready(ready), .po_data(po), .busy(busy), .done(done),
    .signature(signature), .pattern_count(pattern_count)
  );

  pi_stimulus_gen #(.RAND_COUNT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .pi_data(pi_data0), .pi_valid(pi_valid0),
    .pi_ready(ready0), .po_data(po), .busy(busy0), .done(done0),
    .signature(signature0), .pattern_count(pattern_count0)
  );

  // Reference MISR step: multiply by x modulo the polynomial, then add the outputs.
  function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic [4:0] p);
    int v;
    v = (int'(s) * 2) % 65536;
    if (int'(s) >= 32768) v = v ^ 'h1021;
    v = v ^ int'(p);
    return 16'(v);
  endfunction

  // Expected pattern list: sweep 0..63, then successive LFSR states mod 64.
  function automatic void build_patterns();
    int l;
    for (int i = 0; i < 64; i++) exp_pat[i] = i;
    l = 'hACE1;
    for (int i = 64; i < N_RUN; i++) begin
      exp_pat[i] = l % 64;
      l = (l % 2 == 1) ? ((l / 2) ^ 'hB400) : (l / 2);
    end
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drives ready/po each cycle until n_hs handshakes; checks the presented pattern.
  task automatic stream(input int n_hs, input int ready_pct, input int po_mode,
                        inout int hs, inout logic [15:0] sig);
    int cyc;
    cyc = 0;
    while (hs < n_hs && cyc < 4000) begin
      ready = ($urandom_range(0, 99) < ready_pct);
      case (po_mode)
        0:       po = 5'h00;
        1:       po = (hs < 2) ? 5'h01 : 5'h00;
        default: po = po_tab[hs];
      endcase
      checks++;
      if (pi_valid !== 1'b1 || pi_data !== 6'(exp_pat[hs]) ||
          pattern_count !== 16'(hs) || signature !== sig) begin
        if (nprint < 20)
          $display("FAIL stream hs=%0d: valid=%b data=%0d count=%0d sig=%h, need valid=1 data=%0d count=%0d sig=%h",
                   hs, pi_valid, pi_data, pattern_count, signature, exp_pat[hs], hs, sig);
        nprint++;
      end else passes++;
      @(posedge clk);
      if (ready) begin
        sig = misr_ref(sig, po);
        hs++;
      end
      #1;
      cyc++;
    end
    checks++;
    if (hs < n_hs) $display("FAIL stream_timeout: got %0d handshakes, need %0d", hs, n_hs);
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({pi_data, pi_valid, busy, done, signature, pattern_count} !== 40'd0)
      $display("FAIL reset_values: data=%0d valid=%b busy=%b done=%b sig=%h count=%0d, need all zero",
               pi_data, pi_valid, busy, done, signature, pattern_count);
    else passes++;
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (pi_valid !== 1'b0 || busy !== 1'b0 || pi_valid0 !== 1'b0 || done0 !== 1'b0)
      $display("FAIL start_with_reset: valid=%b busy=%b valid0=%b done0=%b, need 0 0 0 0",
               pi_valid, busy, pi_valid0, done0);
    else passes++;
    $display("reset: outputs idle");
  endtask

  task automatic test_default_run();
    int hs;
    logic [15:0] sig;
    hs = 0; sig = '0;
    do_start();
    checks++;
    if (pi_valid !== 1'b1 || busy !== 1'b1 || pi_data !== 6'd0)
      $display("FAIL first_pattern: valid=%b busy=%b data=%0d, need 1 1 0", pi_valid, busy, pi_data);
    else passes++;
    stream(64, 100, 0, hs, sig);
    checks++;
    if (pi_data !== 6'd33) $display("FAIL first_random: data=%0d, need 33", pi_data);
    else passes++;
    stream(N_RUN, 100, 0, hs, sig);
    checks++;
    if ({done, pi_valid, busy, pattern_count, signature} !== {1'b1, 1'b0, 1'b0, 16'd320, 16'h0000})
      $display("FAIL default_done: done=%b valid=%b busy=%b count=%0d sig=%h, need 1 0 0 320 0000",
               done, pi_valid, busy, pattern_count, signature);
    else passes++;
    $display("run default: handshakes=%0d signature=%h", hs, signature);
  endtask

  task automatic test_backpressure_misr();
    int hs;
    logic [15:0] sig;
    hs = 0; sig = '0;
    do_start();
    stream(2, 100, 1, hs, sig);
    checks++;
    if (signature !== 16'h0003) $display("FAIL misr_two: sig=%h, need 0003", signature);
    else passes++;
    stream(5, 100, 1, hs, sig);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (pi_data !== 6'd5 || pattern_count !== 16'd5 || pi_valid !== 1'b1)
        $display("FAIL backpressure_hold: data=%0d count=%0d valid=%b, need 5 5 1",
                 pi_data, pattern_count, pi_valid);
      else passes++;
    end
    stream(6, 100, 1, hs, sig);
    checks++;
    if (pi_data !== 6'd6) $display("FAIL backpressure_resume: data=%0d, need 6", pi_data);
    else passes++;
    stream(N_RUN, 60, 1, hs, sig);
    checks++;
    if ({done, pi_valid, pattern_count, signature} !== {1'b1, 1'b0, 16'd320, sig})
      $display("FAIL misr_final: done=%b valid=%b count=%0d sig=%h, need 1 0 320 %h",
               done, pi_valid, pattern_count, signature, sig);
    else passes++;
    $display("run backpressure: handshakes=%0d signature=%h", hs, signature);
  endtask

  task automatic test_start_ignored();
    int hs;
    logic [15:0] sig;
    hs = 0; sig = '0;
    do_start();
    checks++;
    if ({signature, pi_data, pattern_count, done, pi_valid} !== {16'h0, 6'd0, 16'd0, 1'b0, 1'b1})
      $display("FAIL restart_from_done: sig=%h data=%0d count=%0d done=%b valid=%b, need 0000 0 0 0 1",
               signature, pi_data, pattern_count, done, pi_valid);
    else passes++;
    stream(10, 80, 2, hs, sig);
    ready = 1'b1;
    po = po_tab[hs];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sig = misr_ref(sig, po);
    hs++;
    stream(N_RUN, 80, 2, hs, sig);
    checks++;
    if ({done, pi_valid, pattern_count, signature} !== {1'b1, 1'b0, 16'd320, sig})
      $display("FAIL start_ignored_final: done=%b valid=%b count=%0d sig=%h, need 1 0 320 %h",
               done, pi_valid, pattern_count, signature, sig);
    else passes++;
    sig_first = sig;
    $display("run start_ignored: handshakes=%0d signature=%h", hs, signature);
  endtask

  task automatic test_reset_midrun();
    int hs;
    logic [15:0] sig;
    hs = 0; sig = '0;
    do_start();
    stream(100, 100, 2, hs, sig);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({pi_data, pi_valid, busy, done, signature, pattern_count} !== 40'd0)
      $display("FAIL async_reset: data=%0d valid=%b busy=%b done=%b sig=%h count=%0d, need all zero",
               pi_data, pi_valid, busy, done, signature, pattern_count);
    else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    hs = 0; sig = '0;
    do_start();
    stream(N_RUN, 100, 2, hs, sig);
    checks++;
    if (done !== 1'b1 || signature !== sig_first)
      $display("FAIL rerun_signature: done=%b sig=%h, need 1 %h", done, signature, sig_first);
    else passes++;
    $display("run after reset: handshakes=%0d signature=%h", hs, signature);
  endtask

  task automatic test_rand0();
    po = 5'h00;
    ready0 = 1'b1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int i = 0; i < N_R0; i++) begin
      checks++;
      if (pi_valid0 !== 1'b1 || pi_data0 !== 6'(i))
        $display("FAIL rand0_pattern %0d: valid=%b data=%0d, need 1 %0d", i, pi_valid0, pi_data0, i);
      else passes++;
      @(posedge clk); #1;
    end
    checks++;
    if ({done0, pi_valid0, busy0, pattern_count0} !== {1'b1, 1'b0, 1'b0, 16'd64})
      $display("FAIL rand0_done: done=%b valid=%b busy=%b count=%0d, need 1 0 0 64",
               done0, pi_valid0, busy0, pattern_count0);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (pi_valid0 !== 1'b0 || done0 !== 1'b1)
      $display("FAIL rand0_after: valid=%b done=%b, need 0 1", pi_valid0, done0);
    else passes++;
    $display("run rand0: handshakes=%0d signature=%h", pattern_count0, signature0);
  endtask

  initial begin
    build_patterns();
    for (int i = 0; i < N_RUN; i++) po_tab[i] = 5'($urandom);
    #1;
    test_reset();
    test_default_run();
    test_backpressure_misr();
    test_start_ignored();
    test_reset_midrun();
    test_rand0();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
